// File: rtl/diferenca_pkg.sv
// diferenca_pkg -- shared constants for the difference display.
//   Active-low segment glyphs in {g,f,e,d,c,b,a} order.
//   Digit-index enumeration: units, tens, sign.
//   Digit count.
package diferenca_pkg;

  localparam int NUM_DIGITS = 3;

  // Scan position. The numeric value is the an[] bit that is driven low.
  typedef enum logic [1:0] {
    DIGIT_UNITS = 2'd0,
    DIGIT_TENS  = 2'd1,
    DIGIT_SIGN  = 2'd2
  } digit_idx_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/decod7seg.sv
// decod7seg -- combinational 4-bit value to active-low 7-segment glyph.
//   value : input  [3:0] digit value; 0-9 give the decimal glyph
//   seg   : output [6:0] {g,f,e,d,c,b,a}, active-low; 10-15 give blank
module decod7seg
  import diferenca_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/diferenca_display.sv
// diferenca_display -- holds a signed magnitude (0..15 plus sign) and
// time-multiplexes it onto three active-low 7-segment digits.
//   REFRESH_DIV : clock cycles each digit stays enabled (>= 2)
//   clk         : system clock, rising edge
//   rst         : synchronous reset, active-high, priority over load
//   load        : capture strobe for S and sinal
//   S [3:0]     : unsigned magnitude
//   sinal       : sign, 1 = negative
//   seg [6:0]   : registered segment drive, active-low, {g,f,e,d,c,b,a}
//   an [2:0]    : registered digit enables, active-low; 0=units 1=tens 2=sign
// Build option: define DIFF_DISP_BLANK_EN to blank the tens digit for
// magnitudes below 10 (otherwise it shows '0').
module diferenca_display
  import diferenca_pkg::*;
#(
  parameter int REFRESH_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] S,
  input  logic       sinal,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [3:0]            mag_q, mag_d;
  logic                  neg_q, neg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  digit_idx_e            idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic       tens_flag;
  logic [3:0] units_val;
  logic [3:0] tens_val;
  logic [6:0] units_seg;
  logic [6:0] tens_seg;
  logic [6:0] tens_glyph;

  decod7seg u_units (
    .value (units_val),
    .seg   (units_seg)
  );

  decod7seg u_tens (
    .value (tens_val),
    .seg   (tens_seg)
  );

  // Digit enables follow the scan index that is current before the edge.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
      assign an_d[gi] = (int'(idx_q) != gi);
    end
  endgenerate

  always_comb begin
    mag_d = mag_q;
    neg_d = neg_q;
    if (load) begin
      mag_d = S;
      // A zero magnitude is never shown as negative.
      neg_d = sinal && (S != 4'd0);
    end

    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      case (idx_q)
        DIGIT_UNITS: idx_d = DIGIT_TENS;
        DIGIT_TENS:  idx_d = DIGIT_SIGN;
        default:     idx_d = DIGIT_UNITS;
      endcase
    end

    tens_flag = (mag_q >= 4'd10);
    units_val = tens_flag ? (mag_q - 4'd10) : mag_q;
    tens_val  = {3'b000, tens_flag};

`ifdef DIFF_DISP_BLANK_EN
    tens_glyph = tens_flag ? tens_seg : SEG_BLANK;
`else
    tens_glyph = tens_seg;
`endif

    case (idx_q)
      DIGIT_UNITS: seg_d = units_seg;
      DIGIT_TENS:  seg_d = tens_glyph;
      DIGIT_SIGN:  seg_d = neg_q ? SEG_MINUS : SEG_BLANK;
      default:     seg_d = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q <= 4'd0;
      neg_q <= 1'b0;
      cnt_q <= '0;
      idx_q <= DIGIT_UNITS;
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else begin
      mag_q <= mag_d;
      neg_q <= neg_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_diferenca_display.sv
// tb_diferenca_display -- directed stimulus with a cycle-tagged scoreboard.
// The stimulus process queues the hand-computed {an,seg} expected after a
// given clock edge; a monitor on the falling edge pops and compares them.
module tb_diferenca_display;

  localparam logic [6:0] G_0     = 7'b1000000;
  localparam logic [6:0] G_1     = 7'b1111001;
  localparam logic [6:0] G_2     = 7'b0100100;
  localparam logic [6:0] G_3     = 7'b0110000;
  localparam logic [6:0] G_7     = 7'b1111000;
  localparam logic [6:0] G_MINUS = 7'b0111111;
  localparam logic [6:0] G_BLANK = 7'b1111111;
`ifdef DIFF_DISP_BLANK_EN
  localparam logic [6:0] TENS_ZERO = 7'b1111111;
`else
  localparam logic [6:0] TENS_ZERO = 7'b1000000;
`endif
  localparam logic [2:0] AN_U = 3'b110;
  localparam logic [2:0] AN_T = 3'b101;
  localparam logic [2:0] AN_S = 3'b011;
  localparam logic [2:0] AN_R = 3'b111;
  localparam int B = 3;   // reset edges before the scan starts

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] S;
  logic       sinal;
  logic [6:0] seg;
  logic [2:0] an;

  typedef struct {
    int         cyc;
    logic [2:0] an;
    logic [6:0] seg;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   ecnt = 0;
  int   checks = 0;
  int   errors = 0;
  logic rst_at_edge = 1'b1;

  diferenca_display #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .S     (S),
    .sinal (sinal),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ecnt        <= ecnt + 1;
    rst_at_edge <= rst;
  end

  task automatic push(input int c, input logic [2:0] a, input logic [6:0] s, input string n);
    exp_t e;
    e.cyc = c; e.an = a; e.seg = s; e.name = n;
    sb_q.push_back(e);
  endtask

  // Monitor: one-hot enable check every running cycle, plus scoreboard pops.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_at_edge) begin
      checks++;
      if ($countones(~an) != 1) begin
        errors++;
        $display("FAIL onehot cyc=%0d an=%b required exactly one low bit", ecnt, an);
      end
    end
    while (sb_q.size() > 0 && sb_q[0].cyc <= ecnt) begin
      e = sb_q.pop_front();
      checks++;
      if (e.cyc < ecnt) begin
        errors++;
        $display("FAIL %s cyc=%0d missed (now %0d)", e.name, e.cyc, ecnt);
      end else if (an !== e.an || seg !== e.seg) begin
        errors++;
        $display("FAIL %s cyc=%0d got an=%b seg=%b required an=%b seg=%b",
                 e.name, ecnt, an, seg, e.an, e.seg);
      end else begin
        $display("check %s cyc=%0d an=%b seg=%b ok", e.name, ecnt, an, seg);
      end
    end
  end

  initial begin
    exp_t e;
    // Reset held for three edges with a load that must be discarded.
    rst = 1'b1; load = 1'b1; S = 4'd5; sinal = 1'b1;
    push(1, AN_R, G_BLANK, "reset1");
    push(2, AN_R, G_BLANK, "reset2");
    push(3, AN_R, G_BLANK, "reset3");

    // First full scan with value 0: 4 cycles per digit.
    for (int k = 1; k <= 12; k++) begin
      if (k <= 4)      push(B + k, AN_U, G_0, "scan_units0");
      else if (k <= 8) push(B + k, AN_T, TENS_ZERO, "scan_tens0");
      else             push(B + k, AN_S, G_BLANK, "scan_sign_blank");
    end
    // S=13 negative, loaded at edge 12.
    push(B + 13, AN_U, G_3,     "m13_units");
    push(B + 17, AN_T, G_1,     "m13_tens");
    push(B + 21, AN_S, G_MINUS, "m13_sign");
    // S=0 with sinal=1, loaded at edge 24: no negative zero.
    push(B + 25, AN_U, G_0,       "negzero_units");
    push(B + 29, AN_T, TENS_ZERO, "negzero_tens");
    push(B + 33, AN_S, G_BLANK,   "negzero_sign");
    // S=7 positive, loaded at edge 36.
    push(B + 37, AN_U, G_7,       "m7_units");
    push(B + 41, AN_T, TENS_ZERO, "m7_tens");
    push(B + 45, AN_S, G_BLANK,   "m7_sign");
    // Back-to-back loads at edges 47 (11,neg) and 48 (2,pos; a wrap edge).
    push(B + 49, AN_U, G_2,       "b2b_units");
    push(B + 53, AN_T, TENS_ZERO, "b2b_tens");
    push(B + 57, AN_S, G_BLANK,   "b2b_sign");
    // S=9 on wrap edge 60, reset with load on edge 61.
    push(B + 60, AN_S, G_BLANK,   "wrap_load_sign");
    push(B + 61, AN_R, G_BLANK,   "midscan_reset");
    push(B + 62, AN_U, G_0,       "post_reset_units");
    push(B + 66, AN_T, TENS_ZERO, "post_reset_tens");
    push(B + 70, AN_S, G_BLANK,   "post_reset_sign");

    repeat (B) @(posedge clk);
    #1;
    rst = 1'b0; load = 1'b0;

    for (int k = 1; k <= 72; k++) begin
      rst = 1'b0; load = 1'b0;
      case (k)
        12: begin load = 1'b1; S = 4'd13; sinal = 1'b1; end
        24: begin load = 1'b1; S = 4'd0;  sinal = 1'b1; end
        36: begin load = 1'b1; S = 4'd7;  sinal = 1'b0; end
        47: begin load = 1'b1; S = 4'd11; sinal = 1'b1; end
        48: begin load = 1'b1; S = 4'd2;  sinal = 1'b0; end
        60: begin load = 1'b1; S = 4'd9;  sinal = 1'b0; end
        61: begin rst = 1'b1; load = 1'b1; S = 4'd5; sinal = 1'b1; end
        default: ;
      endcase
      @(posedge clk);
      #1;
    end
    rst = 1'b0; load = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Anything still queued was never reached by the monitor.
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s timeout: expected at cyc=%0d, run ended at cyc=%0d", e.name, e.cyc, ecnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/diferenca_display.md
DIFERENCA_DISPLAY -- requirements
Module: diferenca_display

Interface
REQ-001 Parameter: REFRESH_DIV, default 1000, clock cycles each digit stays enabled; legal range >= 2.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 load  input  1  capture strobe; S and sinal are sampled on every rising edge where load=1.
REQ-005 S  input  4  magnitude from the difference stage, unsigned 0..15.
REQ-006 sinal  input  1  sign from the difference stage; 1 = negative.
REQ-007 seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-008 an  output  3  digit enables, active-low, one-hot-low: an[0] = units, an[1] = tens, an[2] = sign.

Function
REQ-009 Held value: mag_reg[3:0] and neg_reg capture S and sinal on load=1; they hold otherwise.
REQ-010 Negative-zero rule: if S=0 at capture, neg_reg is stored as 0 regardless of sinal.
REQ-011 Digit split: tens = 1 when mag_reg >= 10, else 0; units = mag_reg - 10*tens.
REQ-012 Refresh counter: cnt counts 0..REFRESH_DIV-1, then wraps to 0.
REQ-013 Scan index: idx advances 0->1->2->0 on the cycle cnt wraps; idx holds on all other cycles.
REQ-014 Digit content: idx=0 shows the units glyph; idx=1 shows the tens glyph; idx=2 shows '-' (seg=7'b0111111) when neg_reg=1, else blank (7'b1111111).
REQ-015 seg and an are registered; each reflects the idx, mag_reg and neg_reg values present before the same edge.
REQ-016 Latency: a load sampled at edge N appears on seg at edge N+1 for whichever digit is then active.
REQ-017 A load does not disturb cnt or idx; the scan continues uninterrupted.
REQ-018 Load on the same edge as a cnt wrap: both take effect on that edge.
REQ-019 Back-to-back loads: the last sampled value wins; no value is queued.
REQ-020 Exactly one an bit is low on every cycle after the first post-reset edge.
REQ-021 Glyphs 0-9 use the standard active-low 7-segment codes, e.g. 0=7'b1000000, 5=7'b0010010, 9=7'b0010000.

Reset
REQ-022 On an edge with rst=1: mag_reg=0, neg_reg=0, cnt=0, idx=0, seg=7'b1111111, an=3'b111.
REQ-023 First edge after rst falls: an=3'b110, seg = glyph '0'.
REQ-024 rst has priority over load; a load asserted together with rst is discarded.
REQ-025 Asserting rst mid-scan returns the block to the REQ-022 state on that edge.

Configuration
REQ-026 Macro DIFF_DISP_BLANK_EN: when defined, the tens digit shows blank (7'b1111111) when mag_reg < 10; when undefined, it shows glyph '0'.
REQ-027 The macro has no other effect; scan timing and an behaviour are identical with and without it.

Structure
REQ-028 Package diferenca_pkg holds:
- segment glyph constants (digits 0-9, SEG_MINUS, SEG_BLANK);
- the digit-index constants for units, tens and sign;
- the digit count, 3.
REQ-029 Sub-module decod7seg is the combinational 4-bit to 7-segment glyph decoder, used for the units and tens digits.
REQ-030 cnt is sized as $clog2(REFRESH_DIV) bits.

Verification
REQ-031 Reset, REFRESH_DIV=4 -> an=110, seg=1000000 for 4 cycles, then an=101 for 4 cycles, then an=011 with seg=1111111.
REQ-032 load with S=13, sinal=1 -> units digit 0110000 (3), tens digit 1111001 (1), sign digit 0111111.
REQ-033 load with S=0, sinal=1 -> sign digit blank, units digit 1000000.
REQ-034 load with S=7, sinal=0 -> tens digit 1111111 with the macro, 1000000 without; sign digit blank.
REQ-035 load with S=9 on a cnt-wrap edge, then rst with load=1 on the next edge -> idx advances on the wrap edge; reset state per REQ-022 afterwards, value 0 held.
